// File: rtl/seq_mag_cmp_pkg.sv
// Shared types and the cascade resolution rule for the digit-serial magnitude comparator.
package seq_mag_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_LT = 2'd0,
      RES_EQ = 2'd1,
      RES_GT = 2'd2
   } res_t;

   // Used only once every local digit has matched; equal wins, then greater, then less.
   function automatic res_t cascade_res(input logic l, input logic e, input logic g);
      res_t r;
      if (e)
         r = RES_EQ;
      else if (g)
         r = RES_GT;
      else if (l)
         r = RES_LT;
      else
         r = RES_EQ;
      return r;
   endfunction

endpackage

// File: rtl/seq_mag_cmp_cmp_digit.sv
// One DIGIT-wide unsigned comparison slice; the top feeds it the current MSB-first digit.
import seq_mag_cmp_pkg::*;

module cmp_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] da,
   input  logic [DIGIT-1:0] db,
   output logic             d_lt,
   output logic             d_eq,
   output logic             d_gt
);

   assign d_lt = (da <  db);
   assign d_eq = (da == db);
   assign d_gt = (da >  db);

endmodule

// File: rtl/seq_mag_cmp.sv
// Digit-serial, cascadable magnitude comparator: MSB-first, early exit on first unequal digit.
// Define SIGNED_CMP_EN to treat operands as two's complement.
import seq_mag_cmp_pkg::*;

module seq_mag_cmp #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             l_in,
   input  logic             e_in,
   input  logic             g_in,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int N  = WIDTH / DIGIT;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             l_q, e_q, g_q;
   logic [IW-1:0]    idx_q;
   logic             lt_q, eq_q, gt_q;

   logic [DIGIT-1:0] da, db;
   logic             d_lt, d_eq, d_gt;
   logic             accept, decide;
   res_t             res_d;

   // Operands shift left after each matching digit, so the live digit is always the top one.
   always_comb begin
      da = a_q[WIDTH-1 -: DIGIT];
      db = b_q[WIDTH-1 -: DIGIT];
`ifdef SIGNED_CMP_EN
      if (idx_q == LAST_IDX) begin
         da[DIGIT-1] = ~da[DIGIT-1];
         db[DIGIT-1] = ~db[DIGIT-1];
      end
`endif
   end

   cmp_digit #(
      .DIGIT (DIGIT)
   ) u_cmp_digit (
      .da   (da),
      .db   (db),
      .d_lt (d_lt),
      .d_eq (d_eq),
      .d_gt (d_gt)
   );

   always_comb begin
      res_d = cascade_res(l_q, e_q, g_q);
      if (d_gt)
         res_d = RES_GT;
      else if (d_lt)
         res_d = RES_LT;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      decide  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!d_eq || (idx_q == '0)) begin
               decide  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: operand and index registers are reset too, so a mid-run abort leaves no stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         l_q   <= 1'b0;
         e_q   <= 1'b0;
         g_q   <= 1'b0;
         idx_q <= '0;
         lt_q  <= 1'b0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         l_q   <= l_in;
         e_q   <= e_in;
         g_q   <= g_in;
         idx_q <= LAST_IDX;
         lt_q  <= 1'b0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
      end else if (decide) begin
         lt_q  <= (res_d == RES_LT);
         eq_q  <= (res_d == RES_EQ);
         gt_q  <= (res_d == RES_GT);
      end else if (state_q == RUN) begin
         a_q   <= a_q << DIGIT;
         b_q   <= b_q << DIGIT;
         idx_q <= idx_q - IW'(1);
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Self-checking bench for seq_mag_cmp: vector table, hand-written corner sequences, random vs model.
module tb_seq_mag_cmp;

`ifdef SIGNED_CMP_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   localparam int R_LT = 0;
   localparam int R_EQ = 1;
   localparam int R_GT = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main instance: WIDTH=8, DIGIT=2
   logic       start, l_in, e_in, g_in;
   logic [7:0] a, b;
   logic       busy, done, lt, eq, gt;

   // two wider instances sharing stimulus: WIDTH=12 with DIGIT=3 and DIGIT=1
   logic        start_w, lw, ew, gw;
   logic [11:0] aw, bw;
   logic        busy3, done3, lt3, eq3, gt3;
   logic        busy1, done1, lt1, eq1, gt1;

   int total = 0;
   int bad   = 0;

   seq_mag_cmp #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .l_in(l_in), .e_in(e_in), .g_in(g_in),
      .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
   );

   seq_mag_cmp #(.WIDTH(12), .DIGIT(3)) dut_d3 (
      .clk(clk), .rst_n(rst_n), .start(start_w), .a(aw), .b(bw),
      .l_in(lw), .e_in(ew), .g_in(gw),
      .busy(busy3), .done(done3), .lt(lt3), .eq(eq3), .gt(gt3)
   );

   seq_mag_cmp #(.WIDTH(12), .DIGIT(1)) dut_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_w), .a(aw), .b(bw),
      .l_in(lw), .e_in(ew), .g_in(gw),
      .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] res_bits(input int r);
      return (r == R_LT) ? 3'b100 : (r == R_GT) ? 3'b001 : 3'b010;
   endfunction

   // Reference: whole-word arithmetic compare, cascade only on full equality,
   // k = 1-based position (from MSB) of the first differing digit, or N if none.
   function automatic void model(input int w, input int dg, input logic [31:0] x, input logic [31:0] y,
                                 input logic l, input logic e, input logic g,
                                 output int res, output int k);
      longint     sx, sy;
      logic [31:0] m;
      int          n;
      bit          found;
      n     = w / dg;
      m     = (32'd1 << dg) - 32'd1;
      k     = n;
      found = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!found && (((x >> (w - dg * (i + 1))) & m) != ((y >> (w - dg * (i + 1))) & m))) begin
            k     = i + 1;
            found = 1'b1;
         end
      end
      sx = longint'(x);
      sy = longint'(y);
      if (SGN && x[w-1]) sx = sx - (longint'(1) << w);
      if (SGN && y[w-1]) sy = sy - (longint'(1) << w);
      if (x == y)
         res = e ? R_EQ : g ? R_GT : l ? R_LT : R_EQ;
      else
         res = (sx > sy) ? R_GT : R_LT;
   endfunction

   // One transaction on the 8-bit instance, starting from IDLE.
   task automatic run8(input string name, input logic [7:0] xa, input logic [7:0] xb,
                       input logic xl, input logic xe, input logic xg,
                       input int exp_res, input int exp_k);
      int cyc;
      a = xa; b = xb; l_in = xl; e_in = xe; g_in = xg;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({name, " busy"}, {31'd0, busy}, 32'd1);
      check({name, " clear"}, {29'd0, lt, eq, gt}, 32'd0);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, cyc, exp_k);
      check({name, " result"}, {29'd0, lt, eq, gt}, {29'd0, res_bits(exp_res)});
      tick();
      check({name, " pulse"}, {31'd0, done}, 32'd0);
      check({name, " hold"}, {29'd0, lt, eq, gt}, {29'd0, res_bits(exp_res)});
   endtask

   // One transaction on both 12-bit instances at once.
   task automatic run12(input string name, input logic [11:0] xa, input logic [11:0] xb,
                        input logic xl, input logic xe, input logic xg,
                        input int exp_res, input int exp_k3, input int exp_k1);
      int         c3, c1;
      logic [2:0] o3, o1;
      aw = xa; bw = xb; lw = xl; ew = xe; gw = xg;
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      c3 = -1; c1 = -1; o3 = '0; o1 = '0;
      for (int c = 1; c <= 30 && (c3 < 0 || c1 < 0); c++) begin
         tick();
         if (done3 === 1'b1 && c3 < 0) begin c3 = c; o3 = {lt3, eq3, gt3}; end
         if (done1 === 1'b1 && c1 < 0) begin c1 = c; o1 = {lt1, eq1, gt1}; end
      end
      tick();
      check({name, " d3 latency"}, c3, exp_k3);
      check({name, " d3 result"}, {29'd0, o3}, {29'd0, res_bits(exp_res)});
      check({name, " d1 latency"}, c1, exp_k1);
      check({name, " d1 result"}, {29'd0, o1}, {29'd0, res_bits(exp_res)});
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       l, e, g;
      int         res;
      int         k;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int          cyc, r, k, r3, k3, r1, k1;
      bit          seen;
      logic [7:0]  xa, xb;
      logic [11:0] ya, yb;
      logic [2:0]  cas;

      vecs[0]  = '{8'hA5, 8'h25, 1'b0, 1'b0, 1'b0, SGN ? R_LT : R_GT, 1};
      vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, R_EQ, 4};
      vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, R_GT, 4};
      vecs[3]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, R_LT, 4};
      vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, R_EQ, 4};
      vecs[5]  = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b0, R_LT, 4};
      vecs[6]  = '{8'h80, 8'h01, 1'b0, 1'b0, 1'b0, SGN ? R_LT : R_GT, 1};
      vecs[7]  = '{8'h34, 8'h38, 1'b0, 1'b0, 1'b0, R_LT, 3};
      vecs[8]  = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, R_GT, 4};
      vecs[9]  = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, SGN ? R_GT : R_LT, 1};
      vecs[10] = '{8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1, R_EQ, 4};
      vecs[11] = '{8'h12, 8'h12, 1'b0, 1'b0, 1'b1, R_GT, 4};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; l_in = 1'b0; e_in = 1'b0; g_in = 1'b0;
      start_w = 1'b0; aw = '0; bw = '0; lw = 1'b0; ew = 1'b0; gw = 1'b0;
      tick();
      tick();
      check("reset outputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle after reset", {27'd0, busy, done, lt, eq, gt}, 32'd0);

      for (int i = 0; i < 12; i++)
         run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].e, vecs[i].g,
              vecs[i].res, vecs[i].k);

      // abort mid-run: no done, all outputs cleared, next compare unaffected
      a = 8'h01; b = 8'h02; l_in = 1'b0; e_in = 1'b0; g_in = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort outputs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      check("abort no done", {31'd0, seen}, 32'd0);
      rst_n = 1'b1;
      tick();
      run8("after abort", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, R_LT, 4);

      // start held high: ignored while busy, accepted in the done cycle; operands change mid-run
      a = 8'h3C; b = 8'h3C; l_in = 1'b0; e_in = 1'b1; g_in = 1'b0;
      start = 1'b1;
      tick();
      check("b2b busy1", {31'd0, busy}, 32'd1);
      tick();
      a = 8'h00; b = 8'hFF; e_in = 1'b0; g_in = 1'b1;
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("b2b latency1", cyc, 4);
      check("b2b result1", {29'd0, lt, eq, gt}, {29'd0, res_bits(R_EQ)});
      tick();
      start = 1'b0;
      check("b2b busy2", {31'd0, busy}, 32'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("b2b latency2", cyc, 1);
      check("b2b result2", {29'd0, lt, eq, gt}, {29'd0, res_bits(SGN ? R_GT : R_LT)});
      tick();
      check("b2b idle", {30'd0, busy, done}, 32'd0);

      // random operands, biased toward shared upper digits and equality
      for (int t = 0; t < 60; t++) begin
         xa = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       xb = xa;
            1:       xb = xa ^ 8'($urandom_range(0, 3));
            2:       xb = xa ^ 8'($urandom_range(0, 15));
            default: xb = 8'($urandom);
         endcase
         cas = 3'($urandom);
         model(8, 2, {24'd0, xa}, {24'd0, xb}, cas[2], cas[1], cas[0], r, k);
         run8($sformatf("rnd%0d", t), xa, xb, cas[2], cas[1], cas[0], r, k);
      end

      // wider word, two digit sizes
      run12("w800", 12'h800, 12'h001, 1'b0, 1'b0, 1'b0, SGN ? R_LT : R_GT, 1, 1);
      run12("w5a5", 12'h5A5, 12'h5A5, 1'b1, 1'b0, 1'b0, R_LT, 4, 12);
      for (int t = 0; t < 30; t++) begin
         ya = 12'($urandom);
         case ($urandom_range(0, 2))
            0:       yb = ya;
            1:       yb = ya ^ 12'($urandom_range(0, 63));
            default: yb = 12'($urandom);
         endcase
         cas = 3'($urandom);
         model(12, 3, {20'd0, ya}, {20'd0, yb}, cas[2], cas[1], cas[0], r3, k3);
         model(12, 1, {20'd0, ya}, {20'd0, yb}, cas[2], cas[1], cas[0], r1, k1);
         run12($sformatf("wrnd%0d", t), ya, yb, cas[2], cas[1], cas[0], r3, k3, k1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
